alu: RTL and testbench

- Combinational 32-bit integer ALU for the RV32IM execute stage.
- Implements RV32I arithmetic, logic, shift and compare operations plus the M-extension multiply, divide and remainder operations, selected by a 5-bit code.
- RESULT is combinational and settles within the same cycle.
- A registered copy, clocked on CLK with synchronous reset, feeds the EX/MEM pipeline boundary.

---
 rtl/alu.sv | 126 ++++++++++++
 tb/tb_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// RV32IM execute-stage ALU: single-cycle combinational RESULT/ZERO plus a
// registered RESULT_Q copy for the EX/MEM pipeline boundary.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [4:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic [WIDTH-1:0] RESULT_Q
);

  typedef enum logic [4:0] {
    OpAdd    = 5'b00000,
    OpSll    = 5'b00001,
    OpSlt    = 5'b00010,
    OpSltu   = 5'b00011,
    OpXor    = 5'b00100,
    OpSrl    = 5'b00101,
    OpOr     = 5'b00110,
    OpAnd    = 5'b00111,
    OpMul    = 5'b01000,
    OpMulh   = 5'b01001,
    OpMulhsu = 5'b01010,
    OpMulhu  = 5'b01011,
    OpDiv    = 5'b01100,
    OpDivu   = 5'b01101,
    OpRem    = 5'b01110,
    OpRemu   = 5'b01111,
    OpSub    = 5'b10000,
    OpFwd    = 5'b10001,
    OpSra    = 5'b10101
  } aluOpE;

  logic [4:0]         shiftAmt;
  logic               signedA;
  logic               signedB;
  logic [2*WIDTH-1:0] mulA;
  logic [2*WIDTH-1:0] mulB;
  logic [2*WIDTH-1:0] product;

  logic               divByZero;
  logic               divNegA;
  logic               divNegB;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH-1:0]   divisorS;
  logic [WIDTH-1:0]   divisorU;
  logic [WIDTH-1:0]   magQ;
  logic [WIDTH-1:0]   magR;
  logic [WIDTH-1:0]   quotS;
  logic [WIDTH-1:0]   remS;
  logic [WIDTH-1:0]   result_d;
  logic [WIDTH-1:0]   result_q;

  assign shiftAmt = DATA2[4:0];

  // Operands are extended to full product width according to signedness; the
  // product modulo 2^(2*WIDTH) is then exact for every sign combination.
  always_comb begin
    signedA = (SELECT == OpMul) || (SELECT == OpMulh) || (SELECT == OpMulhsu);
    signedB = (SELECT == OpMul) || (SELECT == OpMulh);
    mulA    = {{WIDTH{signedA & DATA1[WIDTH-1]}}, DATA1};
    mulB    = {{WIDTH{signedB & DATA2[WIDTH-1]}}, DATA2};
    product = mulA * mulB;
  end

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out naturally as
  // quotient 0x80000000 and remainder 0. Zero divisors are patched in the mux.
  always_comb begin
    divByZero = (DATA2 == '0);
    divNegA   = DATA1[WIDTH-1];
    divNegB   = DATA2[WIDTH-1];
    absA      = divNegA ? -DATA1 : DATA1;
    absB      = divNegB ? -DATA2 : DATA2;
    divisorS  = divByZero ? WIDTH'(1) : absB;
    divisorU  = divByZero ? WIDTH'(1) : DATA2;
    magQ      = absA / divisorS;
    magR      = absA % divisorS;
    quotS     = (divNegA ^ divNegB) ? -magQ : magQ;
    remS      = divNegA ? -magR : magR;
  end

  always_comb begin
    result_d = '0;
    case (SELECT)
      OpAdd:    result_d = DATA1 + DATA2;
      OpSub:    result_d = DATA1 - DATA2;
      OpSll:    result_d = DATA1 << shiftAmt;
      OpSlt:    result_d = {{(WIDTH-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
      OpSltu:   result_d = {{(WIDTH-1){1'b0}}, (DATA1 < DATA2)};
      OpXor:    result_d = DATA1 ^ DATA2;
      OpOr:     result_d = DATA1 | DATA2;
      OpAnd:    result_d = DATA1 & DATA2;
      OpSrl:    result_d = DATA1 >> shiftAmt;
      OpSra:    result_d = $unsigned($signed(DATA1) >>> shiftAmt);
      OpFwd:    result_d = DATA2;
      OpMul:    result_d = product[WIDTH-1:0];
      OpMulh,
      OpMulhsu,
      OpMulhu:  result_d = product[2*WIDTH-1:WIDTH];
      OpDiv:    result_d = divByZero ? '1 : quotS;
      OpDivu:   result_d = divByZero ? '1 : DATA1 / divisorU;
      OpRem:    result_d = divByZero ? DATA1 : remS;
      OpRemu:   result_d = divByZero ? DATA1 : DATA1 % divisorU;
      default:  result_d = '0;
    endcase
  end

  assign RESULT = result_d;
  assign ZERO   = (result_d == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign RESULT_Q = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a behavioural reference model checked every
// cycle, randomized operations, plus hand-computed corner cases.
module tb_alu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b10000, SLL = 5'b00001,
                         SLT = 5'b00010, SLTU = 5'b00011, XOR = 5'b00100,
                         OR = 5'b00110, AND = 5'b00111, SRL = 5'b00101,
                         SRA = 5'b10101, FWD = 5'b10001, MUL = 5'b01000,
                         MULH = 5'b01001, MULHSU = 5'b01010, MULHU = 5'b01011,
                         DIV = 5'b01100, DIVU = 5'b01101, REM = 5'b01110,
                         REMU = 5'b01111;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  SELECT;
  logic [31:0] RESULT;
  logic        ZERO;
  logic [31:0] RESULT_Q;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expQ;
  logic [31:0] cmpExp;
  bit          qValid = 1'b0;

  alu #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .RESULT(RESULT), .ZERO(ZERO), .RESULT_Q(RESULT_Q)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain 64-bit integer arithmetic on the operation rules.
  function automatic logic [31:0] refAlu(input logic [4:0] s, input logic [31:0] a,
                                         input logic [31:0] b);
    int     ia, ib;
    longint sa, sb, ua, ub, p;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (s)
      ADD:    return a + b;
      SUB:    return a - b;
      SLL:    return a << b[4:0];
      SLT:    return (ia < ib) ? 32'd1 : 32'd0;
      SLTU:   return (a < b) ? 32'd1 : 32'd0;
      XOR:    return a ^ b;
      OR:     return a | b;
      AND:    return a & b;
      SRL:    return a >> b[4:0];
      SRA:    return 32'(ia >>> b[4:0]);
      FWD:    return b;
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      DIVU:   return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      REMU:   return (b == 32'h0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (sel=%b a=%h b=%h)",
               name, act, exp, SELECT, DATA1, DATA2);
    end
  endtask

  // Expected registered value follows the rule: cleared under RESET, else RESULT.
  always @(posedge CLK) begin
    expQ   <= RESET ? 32'h0 : refAlu(SELECT, DATA1, DATA2);
    qValid <= 1'b1;
  end

  always @(negedge CLK) begin
    cmpExp = refAlu(SELECT, DATA1, DATA2);
    checkEq("model_result", RESULT, cmpExp);
    checkEq("model_zero", {31'b0, ZERO}, {31'b0, (cmpExp == 32'h0)});
    if (qValid) checkEq("model_result_q", RESULT_Q, expQ);
  end

  task automatic applyStimulus(input logic rst, input logic [4:0] s,
                               input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK);
    #1;
    RESET  = rst;
    SELECT = s;
    DATA1  = a;
    DATA2  = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    @(negedge CLK);
    checkEq(name, RESULT, exp);
    checkEq({name, "_zero"}, {31'b0, ZERO}, {31'b0, (exp == 32'h0)});
    checkEq({name, "_model"}, refAlu(SELECT, DATA1, DATA2), exp);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 40));
      5: return 32'h0 - 32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pickSelect();
    logic [4:0] ops [19];
    ops = '{ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA, FWD,
            MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    if ($urandom_range(0, 9) == 0) return 5'($urandom);
    return ops[$urandom_range(0, 18)];
  endfunction

  initial begin
    RESET = 1'b1; SELECT = ADD; DATA1 = 32'd5; DATA2 = 32'd10;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkEq("reset_q", RESULT_Q, 32'h0);
    checkEq("reset_comb", RESULT, 32'd15);

    applyStimulus(1'b0, ADD, 32'd5, 32'd10);
    checkOutput("add", 32'd15);
    @(negedge CLK);
    checkEq("add_q", RESULT_Q, 32'd15);

    applyStimulus(1'b0, SUB, 32'd3, 32'd5);                 checkOutput("sub_neg", 32'hFFFFFFFE);
    applyStimulus(1'b0, SLT, 32'hFFFFFFFF, 32'd1);          checkOutput("slt", 32'd1);
    applyStimulus(1'b0, SLTU, 32'hFFFFFFFF, 32'd1);         checkOutput("sltu", 32'd0);
    applyStimulus(1'b0, SUB, 32'd7, 32'd7);                 checkOutput("sub_zero", 32'd0);
    applyStimulus(1'b0, SLL, 32'h1, 32'h21);                checkOutput("sll_mask", 32'h2);
    applyStimulus(1'b0, SRL, 32'h80000000, 32'd31);         checkOutput("srl", 32'h1);
    applyStimulus(1'b0, SRA, 32'h80000000, 32'd31);         checkOutput("sra", 32'hFFFFFFFF);
    applyStimulus(1'b0, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);   checkOutput("mul", 32'h1);
    applyStimulus(1'b0, MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);  checkOutput("mulh", 32'h0);
    applyStimulus(1'b0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF); checkOutput("mulhu", 32'hFFFFFFFE);
    applyStimulus(1'b0, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);checkOutput("mulhsu", 32'hFFFFFFFF);
    applyStimulus(1'b0, DIV, 32'hFFFFFFF9, 32'd2);          checkOutput("div_trunc", 32'hFFFFFFFD);
    applyStimulus(1'b0, REM, 32'hFFFFFFF9, 32'd2);          checkOutput("rem_sign", 32'hFFFFFFFF);
    applyStimulus(1'b0, DIV, 32'd1234, 32'd0);              checkOutput("div_zero", 32'hFFFFFFFF);
    applyStimulus(1'b0, REMU, 32'd9, 32'd0);                checkOutput("remu_zero", 32'd9);
    applyStimulus(1'b0, DIV, 32'h80000000, 32'hFFFFFFFF);   checkOutput("div_ovf", 32'h80000000);
    applyStimulus(1'b0, REM, 32'h80000000, 32'hFFFFFFFF);   checkOutput("rem_ovf", 32'h0);
    applyStimulus(1'b0, FWD, 32'd3, 32'hABCDE000);          checkOutput("fwd", 32'hABCDE000);
    applyStimulus(1'b0, 5'b11111, 32'd3, 32'd4);            checkOutput("undef_sel", 32'h0);

    applyStimulus(1'b1, ADD, 32'd1, 32'd1);
    checkOutput("rst_add", 32'd2);
    @(negedge CLK);
    checkEq("rst_hold_q", RESULT_Q, 32'h0);
    applyStimulus(1'b0, ADD, 32'd1, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    checkEq("rst_release_q", RESULT_Q, 32'd2);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), pickSelect(), pickOperand(), pickOperand());
    end
    @(negedge CLK);
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
